// File: rtl/payload_char_pkg.sv
// Shared types and the character-class table for the payload byte decoder.
// Each class matches up to two inclusive byte ranges, optionally after folding A-Z to a-z.
package payload_char_pkg;

  localparam int unsigned N_CLASS = 72;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOD,
    S_BYTES,
    S_WAIT,
    S_FLUSH,
    S_EOD
  } state_t;

  typedef struct packed {
    logic [7:0] lo0;
    logic [7:0] hi0;
    logic [7:0] lo1;
    logic [7:0] hi1;
    logic       nocase;
  } class_t;

  typedef class_t [N_CLASS-1:0] class_tab_t;

  // Single-character classes 58..71, first character is class 58
  localparam logic [8*14-1:0] PUNCT_CHARS = "-_?=&%:@#~+;,!";

  function automatic class_t mk_class(input logic [7:0] lo0, input logic [7:0] hi0,
                                      input logic [7:0] lo1, input logic [7:0] hi1,
                                      input logic nocase);
    class_t c;
    c.lo0    = lo0;
    c.hi0    = hi0;
    c.lo1    = lo1;
    c.hi1    = hi1;
    c.nocase = nocase;
    return c;
  endfunction

  // Unused ranges are encoded empty as lo=FF, hi=00.
  function automatic class_t class_entry(input int unsigned k);
    class_t c;
    logic [7:0] ch;
    c  = mk_class(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0);
    ch = '0;
    if (k == 0) begin
      c = mk_class(8'h30, 8'h39, 8'hFF, 8'h00, 1'b0);
    end else if (k == 1) begin
      c = mk_class(8'h61, 8'h7A, 8'hFF, 8'h00, 1'b1);
    end else if (k >= 2 && k < 28) begin
      ch = 8'(32'h61 + k - 2);
      c  = mk_class(ch, ch, 8'hFF, 8'h00, 1'b1);
    end else if (k == 28) begin
      c = mk_class(8'h2E, 8'h2E, 8'hFF, 8'h00, 1'b0);
    end else if (k == 29) begin
      c = mk_class(8'h2F, 8'h2F, 8'hFF, 8'h00, 1'b0);
    end else if (k == 30) begin
      c = mk_class(8'h09, 8'h0D, 8'h20, 8'h20, 1'b0);
    end else if (k == 31) begin
      c = mk_class(8'h00, 8'h1F, 8'h7F, 8'h7F, 1'b0);
    end else if (k >= 32 && k < 58) begin
      ch = 8'(32'h41 + k - 32);
      c  = mk_class(ch, ch, 8'hFF, 8'h00, 1'b0);
    end else if (k >= 58 && k < 72) begin
      ch = 8'(PUNCT_CHARS >> (8 * (71 - k)));
      c  = mk_class(ch, ch, 8'hFF, 8'h00, 1'b0);
    end
    return c;
  endfunction

  function automatic class_tab_t build_class_table();
    class_tab_t t;
    t = '0;
    for (int unsigned k = 0; k < N_CLASS; k++) begin
      t    = t << $bits(class_t);
      t[0] = class_entry(N_CLASS - 1 - k);
    end
    return t;
  endfunction

  localparam class_tab_t CLASS_TABLE = build_class_table();

  function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/char_class_lut.sv
// Combinational byte -> character-class hit vector, driven from the package table.
module char_class_lut
  import payload_char_pkg::*;
(
  input  logic [7:0]         ch,
  output logic [N_CLASS-1:0] hit
);

  logic [7:0] folded;

  always_comb begin
    folded = (ch >= 8'h41 && ch <= 8'h5A) ? (ch | 8'h20) : ch;
  end

  for (genvar k = 0; k < N_CLASS; k++) begin : g_cls
    localparam class_t C = CLASS_TABLE[k];
    logic [7:0] b;
    always_comb begin
      b      = C.nocase ? folded : ch;
      hit[k] = in_range(b, C.lo0, C.hi0) | in_range(b, C.lo1, C.hi1);
    end
  end

endmodule

// File: rtl/payload_char_decoder.sv
// Serialises AXI-Stream payload words into one decoded byte per cycle and
// generates the engine sod/en/eod strobes, including a trailing flush cycle.
module payload_char_decoder #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned N_CLASS = payload_char_pkg::N_CLASS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [N_CLASS-1:0]  char_hit,
  output logic                en,
  output logic                sod,
  output logic                eod
);

  import payload_char_pkg::*;

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CW = $clog2(NB + 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] data, data_n;
  logic [NB-1:0]     keep, keep_n;
  logic              last, last_n;
  logic [IW-1:0]     idx, idx_n;
  logic [CW-1:0]     nvalid, nvalid_n;
  logic              hs, load, last_byte;
  logic              tready_n;
  logic [7:0]        cur_byte;
  logic [N_CLASS-1:0] hit_n;
  logic [payload_char_pkg::N_CLASS-1:0] lut_hit;

  always_comb begin
    hs        = s_tvalid & s_tready;
    nvalid    = CW'($countones(keep));
    last_byte = (CW'(idx) + CW'(1)) == nvalid;
    state_n   = state;
    data_n    = data;
    keep_n    = keep;
    last_n    = last;
    idx_n     = idx;
    load      = 1'b0;
    case (state)
      S_IDLE: if (hs) begin
        load    = 1'b1;
        state_n = S_SOD;
      end
      S_SOD: begin
        idx_n   = '0;
        state_n = (nvalid == '0) ? S_FLUSH : S_BYTES;
      end
      S_BYTES: begin
        if (last_byte) begin
          if (last) begin
            state_n = S_FLUSH;
          end else if (hs) begin
            load = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_WAIT: if (hs) begin
        load    = 1'b1;
        state_n = S_BYTES;
      end
      S_FLUSH: state_n = S_EOD;
      S_EOD:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      data_n = s_tdata;
      keep_n = s_tkeep;
      last_n = s_tlast;
      idx_n  = '0;
    end
    nvalid_n = CW'($countones(keep_n));
    // An empty word reloaded mid-packet has no bytes to stream: go straight to flush
    if (load && state != S_IDLE && nvalid_n == '0) begin
      state_n = S_FLUSH;
    end
  end

  always_comb begin
    cur_byte = 8'(data_n >> {idx_n, 3'b000});
  end

  char_class_lut u_lut (
    .ch  (cur_byte),
    .hit (lut_hit)
  );

  // Outputs are registered from the next state so they line up with that state's cycle
  always_comb begin
    tready_n = (state_n == S_IDLE) || (state_n == S_WAIT) ||
               ((state_n == S_BYTES) && !last_n && ((CW'(idx_n) + CW'(1)) == nvalid_n));
    hit_n    = (state_n == S_BYTES) ? N_CLASS'(lut_hit) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      data     <= '0;
      keep     <= '0;
      last     <= 1'b0;
      idx      <= '0;
      s_tready <= 1'b0;
      char_hit <= '0;
      en       <= 1'b0;
      sod      <= 1'b0;
      eod      <= 1'b0;
    end else begin
      state    <= state_n;
      data     <= data_n;
      keep     <= keep_n;
      last     <= last_n;
      idx      <= idx_n;
      s_tready <= tready_n;
      char_hit <= hit_n;
      en       <= (state_n == S_BYTES) || (state_n == S_FLUSH);
      sod      <= (state_n == S_SOD);
      eod      <= (state_n == S_EOD);
    end
  end

endmodule

// File: tb/tb_payload_char_decoder.sv
// Scoreboard bench: packets push expected strobe/class events; a monitor pops them as the DUT emits them.
module tb_payload_char_decoder;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NB     = 8;
  localparam int unsigned NC     = 72;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_tdata;
  logic [NB-1:0]     s_tkeep;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;
  logic [NC-1:0]     char_hit;
  logic              en, sod, eod;

  always #5 clk = ~clk;

  payload_char_decoder #(.DATA_W(DATA_W), .N_CLASS(NC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .char_hit (char_hit),
    .en       (en),
    .sod      (sod),
    .eod      (eod)
  );

  typedef struct {
    logic          sod;
    logic          en;
    logic          eod;
    logic          rdy;
    logic [NC-1:0] hit;
    int            gap;
  } exp_t;

  exp_t        q[$];
  logic [63:0] pkt_d[$];
  logic [7:0]  pkt_k[$];
  int          pkt_dl[$];
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;
  int          since = 0;
  exp_t        cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference classes, written from the character-class meanings
  function automatic logic [NC-1:0] ref_hits(input logic [7:0] b);
    logic [NC-1:0] h;
    logic [7:0]    lc;
    string         punct;
    punct = "-_?=&%:@#~+;,!";
    h  = '0;
    lc = (b >= "A" && b <= "Z") ? b + 8'd32 : b;
    h[0] = (b >= "0" && b <= "9");
    h[1] = (lc >= "a" && lc <= "z");
    for (int i = 0; i < 26; i++) begin
      h[2 + i]  = (lc == 8'("a" + i));
      h[32 + i] = (b == 8'("A" + i));
    end
    h[28] = (b == ".");
    h[29] = (b == "/");
    h[30] = (b == " ") || (b >= 8'h09 && b <= 8'h0D);
    h[31] = (b < 8'h20) || (b == 8'h7F);
    for (int i = 0; i < 14; i++) h[58 + i] = (b == punct[i]);
    return h;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (sod | en | eod) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got sod/en/eod=%b%b%b expected none", sod, en, eod);
        end else begin
          cur = q.pop_front();
          check("ctrl_sod_en_eod", {125'b0, sod, en, eod}, {125'b0, cur.sod, cur.en, cur.eod});
          check("char_hit", 128'(char_hit), 128'(cur.hit));
          check("ready_in_event", 128'(s_tready), 128'(cur.rdy));
          if (cur.gap >= 0) check("cycle_gap", 128'(since), 128'(cur.gap));
        end
        since = 0;
      end else begin
        since++;
        check("quiet_cycle_ready_hit", {55'b0, s_tready, char_hit}, {55'b0, 1'b1, {NC{1'b0}}});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got s_tready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l, input int delay);
    if (delay > 0) begin
      s_tvalid = 1'b0;
      wait_ready();
      repeat (delay) @(negedge clk);
    end
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic add_word(input logic [63:0] d, input int nbytes, input int delay);
    pkt_d.push_back(d);
    pkt_k.push_back(8'((16'd1 << nbytes) - 16'd1));
    pkt_dl.push_back(delay);
  endtask

  task automatic send_packet();
    exp_t e;
    int   n;
    logic is_last;
    e = '{sod: 1'b1, en: 1'b0, eod: 1'b0, rdy: 1'b0, hit: '0, gap: -1};
    q.push_back(e);
    for (int w = 0; w < pkt_d.size(); w++) begin
      n       = $countones(pkt_k[w]);
      is_last = (w == pkt_d.size() - 1);
      for (int b = 0; b < n; b++) begin
        e.sod = 1'b0;
        e.en  = 1'b1;
        e.eod = 1'b0;
        e.rdy = (b == n - 1) && !is_last;
        e.hit = ref_hits(8'(pkt_d[w] >> (8 * b)));
        e.gap = (b == 0 && w > 0) ? pkt_dl[w] : 0;
        q.push_back(e);
      end
    end
    e = '{sod: 1'b0, en: 1'b1, eod: 1'b0, rdy: 1'b0, hit: '0, gap: 0};
    q.push_back(e);
    e = '{sod: 1'b0, en: 1'b0, eod: 1'b1, rdy: 1'b0, hit: '0, gap: 0};
    q.push_back(e);
    for (int w = 0; w < pkt_d.size(); w++) begin
      send_word(pkt_d[w], pkt_k[w], w == pkt_d.size() - 1, pkt_dl[w]);
    end
    s_tvalid = 1'b0;
    pkt_d.delete();
    pkt_k.delete();
    pkt_dl.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 128'(q.size()), 128'(0));
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [63:0] rand_word();
    string       cs;
    logic [63:0] d;
    cs = "heck.php/ABCxyzKQ019 -_?=&%:@#~+;,!\t";
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 3) == 0) d[8*b +: 8] = 8'($urandom_range(0, 255));
      else d[8*b +: 8] = cs[$urandom_range(0, cs.len() - 1)];
    end
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {52'b0, s_tready, sod, en, eod, char_hit}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(s_tready), 128'(1));
    mon_on = 1'b1;

    add_word(64'h7068702E6B636568, 8, 0);
    send_packet();
    add_word(rand_word(), 8, 0);
    add_word(rand_word(), 3, 0);
    send_packet();
    add_word(rand_word(), 8, 0);
    add_word(rand_word(), 6, 5);
    send_packet();
    add_word(64'h0000_0000_002E_354B, 3, 0);
    send_packet();
    add_word(rand_word(), 0, 0);
    send_packet();
    drain();

    // Reset while bytes are streaming
    mon_on = 1'b0;
    s_tdata  = rand_word();
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    wait_ready();
    @(negedge clk);
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("en_before_reset", 128'(en), 128'(1));
    #2 rst_n = 1'b0;
    #1 check("outputs_in_reset", {52'b0, s_tready, sod, en, eod, char_hit}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 128'(s_tready), 128'(1));
    q.delete();
    since  = 0;
    mon_on = 1'b1;
    add_word(64'h2F61_4B35, 4, 0);
    send_packet();

    for (int p = 0; p < 25; p++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        if (w == nw - 1) add_word(rand_word(), $urandom_range(0, 8), 0);
        else add_word(rand_word(), $urandom_range(1, 8), 0);
        if (w > 0 && $urandom_range(0, 2) == 0) pkt_dl[w] = $urandom_range(1, 4);
      end
      send_packet();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
